ysyx_25070198_bus_arb: RTL and testbench

// Two-master SimpleBus arbiter between the IFU fetch port and the LSU data port and the single memory slave port.
// It replaces the per-master cnt1/cnt2 latency hacks: one outstanding transaction at a time, with a fixed grant.
// The response is routed back to the master that owns the grant, and a watchdog catches a hung slave.
// It sits between ysyx_25070198_ifu/ysyx_25070198_lsu and the memory model (DPI pmem or SRAM wrapper).

---
 rtl/ysyx_25070198_bus_arb.sv | 134 +++++++++++++
 tb/tb_ysyx_25070198_bus_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25070198_bus_arb.sv
// Two-master SimpleBus arbiter: IFU fetch + LSU data onto one memory slave.
// One outstanding transaction, fixed tie priority, watchdog on a hung slave.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ifu_reqValid/raddr         IFU read request (held until respValid)
//   ifu_respValid/rdata        IFU response pulse and fetched word
//   lsu_reqValid/addr/wen/wdata/wmask   LSU request (held until respValid)
//   lsu_respValid/rdata        LSU response pulse; rdata 0 on writes
//   mem_reqValid/addr/wen/wdata/wmask   slave request, fields registered
//   mem_respValid/rdata        slave response
//   bus_err           sticky watchdog-expiry flag
module ysyx_25070198_bus_arb #(
  parameter int TIMEOUT  = 255,
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_raddr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IFU,
    WAIT_LSU,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic in_wait;
  logic tmo;
  logic fin;
  logic pick_lsu;
  logic pick_ifu;

  assign in_wait = (state == WAIT_IFU) ||
                   (state == WAIT_LSU);

  // Watchdog fires only when the slave is silent in the expiry cycle;
  // a response arriving exactly then still wins.
  assign tmo = in_wait && (TIMEOUT != 0) &&
               (cnt == TMAX) && !mem_respValid;
  assign fin = mem_respValid || tmo;

  assign pick_lsu = lsu_reqValid &&
                    (LSU_PRIO || !ifu_reqValid);
  assign pick_ifu = ifu_reqValid && !pick_lsu;

  assign mem_reqValid  = in_wait && !tmo;

  assign ifu_respValid = (state == WAIT_IFU) && fin;
  assign ifu_rdata =
    ((state == WAIT_IFU) && mem_respValid) ?
    mem_rdata : 32'h0;

  assign lsu_respValid = (state == WAIT_LSU) && fin;
  assign lsu_rdata =
    ((state == WAIT_LSU) && mem_respValid && !mem_wen) ?
    mem_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_err   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wen   <= 1'b0;
      mem_wdata <= 32'h0;
      mem_wmask <= 4'h0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          unique case (1'b1)
            pick_lsu: begin
              state     <= WAIT_LSU;
              mem_addr  <= lsu_addr;
              mem_wen   <= lsu_wen;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wen ? lsu_wmask : 4'h0;
            end
            pick_ifu: begin
              state     <= WAIT_IFU;
              mem_addr  <= ifu_raddr;
              mem_wen   <= 1'b0;
              mem_wdata <= 32'h0;
              mem_wmask <= 4'h0;
            end
            default: ;
          endcase
        end
        WAIT_IFU, WAIT_LSU: begin
          if (fin) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
          if (tmo) bus_err <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25070198_bus_arb.sv
// Directed bench for ysyx_25070198_bus_arb.
// Inputs change 1 ns after posedge; outputs sampled 2 ns later.
module tb_ysyx_25070198_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_reqValid;
  logic [31:0] ifu_raddr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_lsu;
  int t_ifu;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_25070198_bus_arb #(
    .TIMEOUT (4),
    .LSU_PRIO(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_reqValid (ifu_reqValid),
    .ifu_raddr    (ifu_raddr),
    .ifu_respValid(ifu_respValid),
    .ifu_rdata    (ifu_rdata),
    .lsu_reqValid (lsu_reqValid),
    .lsu_addr     (lsu_addr),
    .lsu_wen      (lsu_wen),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_respValid(lsu_respValid),
    .lsu_rdata    (lsu_rdata),
    .mem_reqValid (mem_reqValid),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_respValid(mem_respValid),
    .mem_rdata    (mem_rdata),
    .bus_err      (bus_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifu_reqValid = 0; ifu_raddr = 0;
    lsu_reqValid = 0; lsu_addr = 0;
    lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_respValid = 0; mem_rdata = 0;

    // reset state
    tick(); tick(); #2;
    chk("rst_mreq", mem_reqValid, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_iresp", ifu_respValid, 0);
    chk("rst_lresp", lsu_respValid, 0);

    // IFU read, slave answers one cycle after request
    tick(); rst = 0;
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0000;
    tick(); #2;
    chk("i_mreq", mem_reqValid, 1);
    chk("i_maddr", mem_addr, 32'h8000_0000);
    chk("i_mwen", mem_wen, 0);
    chk("i_mmask", mem_wmask, 0);
    chk("i_early", ifu_respValid, 0);
    tick();
    mem_respValid = 1; mem_rdata = 32'h0010_0073;
    #2;
    chk("i_resp", ifu_respValid, 1);
    chk("i_rdata", ifu_rdata, 32'h0010_0073);
    chk("i_lresp", lsu_respValid, 0);
    tick();
    mem_respValid = 0; ifu_reqValid = 0;
    #2;
    chk("i_done_mreq", mem_reqValid, 0);
    chk("i_done_resp", ifu_respValid, 0);
    tick();

    // LSU write
    lsu_reqValid = 1; lsu_addr = 32'h8000_1000;
    lsu_wen = 1; lsu_wdata = 32'hA5A5_A5A5;
    lsu_wmask = 4'b0011;
    tick(); #2;
    chk("w_mreq", mem_reqValid, 1);
    chk("w_maddr", mem_addr, 32'h8000_1000);
    chk("w_mwen", mem_wen, 1);
    chk("w_mwdata", mem_wdata, 32'hA5A5_A5A5);
    chk("w_mmask", mem_wmask, 4'b0011);
    tick();
    mem_respValid = 1; mem_rdata = 32'hDEAD_BEEF;
    #2;
    chk("w_resp", lsu_respValid, 1);
    chk("w_rdata", lsu_rdata, 0);
    chk("w_iresp", ifu_respValid, 0);
    tick();
    mem_respValid = 0; lsu_reqValid = 0; lsu_wen = 0;
    tick();

    // tie: LSU read wins, IFU served after DONE
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0010;
    lsu_reqValid = 1; lsu_addr = 32'h8000_2000;
    lsu_wen = 0; lsu_wmask = 4'hF;
    tick(); #2;
    chk("t_maddr", mem_addr, 32'h8000_2000);
    chk("t_mmask", mem_wmask, 0);
    tick();
    mem_respValid = 1; mem_rdata = 32'h1111_2222;
    #2;
    chk("t_lresp", lsu_respValid, 1);
    chk("t_lrdata", lsu_rdata, 32'h1111_2222);
    chk("t_iresp0", ifu_respValid, 0);
    t_lsu = cyc;
    tick();
    mem_respValid = 0; lsu_reqValid = 0;
    #2;
    chk("t_done_mreq", mem_reqValid, 0);
    tick(); tick(); #2;
    chk("t_imreq", mem_reqValid, 1);
    chk("t_imaddr", mem_addr, 32'h8000_0010);
    tick();
    mem_respValid = 1; mem_rdata = 32'h3333_4444;
    #2;
    chk("t_iresp", ifu_respValid, 1);
    chk("t_irdata", ifu_rdata, 32'h3333_4444);
    t_ifu = cyc;
    chk("t_gap", 32'(t_ifu - t_lsu >= 3), 1);
    tick();
    mem_respValid = 0; ifu_reqValid = 0;
    tick();

    // hung slave, TIMEOUT=4
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0020;
    mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      chk($sformatf("to_wait%0d_mreq", k), mem_reqValid, 1);
      chk($sformatf("to_wait%0d_resp", k), ifu_respValid, 0);
    end
    tick(); #2;
    chk("to_resp", ifu_respValid, 1);
    chk("to_rdata", ifu_rdata, 0);
    chk("to_mreq", mem_reqValid, 0);
    tick();
    ifu_reqValid = 0;
    #2;
    chk("to_err", bus_err, 1);
    chk("to_done_resp", ifu_respValid, 0);
    tick(); tick(); #2;
    chk("to_err_sticky", bus_err, 1);

    // reset during WAIT_LSU
    lsu_reqValid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 0;
    tick(); #2;
    chk("r_mreq", mem_reqValid, 1);
    rst = 1;
    tick();
    rst = 0; lsu_reqValid = 0;
    mem_respValid = 1; mem_rdata = 32'h5555_6666;
    #2;
    chk("r_lresp", lsu_respValid, 0);
    chk("r_mreq0", mem_reqValid, 0);
    chk("r_maddr", mem_addr, 0);
    chk("r_err", bus_err, 0);

    // spurious slave response in IDLE
    tick(); #2;
    chk("s_iresp", ifu_respValid, 0);
    chk("s_lresp", lsu_respValid, 0);
    tick();
    mem_respValid = 0;
    #2;
    chk("s_mreq", mem_reqValid, 0);
    chk("s_lresp2", lsu_respValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
